// File: rtl/ysyx_25020037_gpr_commit.sv
// Write-back commit stage: takes one retired-instruction packet, updates the
// GPR file and machine CSRs, then hands the next PC to the IFU.
module ysyx_25020037_gpr_commit #(
   parameter int              NR_REG = 32,
   parameter int              XLEN   = 32,
   parameter logic [XLEN-1:0] RST_PC = 32'h3000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_valid,
   output logic            gpr_ready,
   input  logic [4:0]      wb_rd,
   input  logic            wb_gpr_we,
   input  logic [XLEN-1:0] wb_gpr_wdata,
   input  logic            wb_csr_we,
   input  logic [11:0]     wb_csr_addr,
   input  logic [XLEN-1:0] wb_csr_wdata,
   input  logic [XLEN-1:0] wb_next_pc,
   output logic            commit_valid,
   input  logic            ifu_ready,
   output logic [XLEN-1:0] commit_pc,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata
);

   localparam int          AW       = $clog2(NR_REG);
   localparam logic [31:0] NR_REG_U = NR_REG;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h1800);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;

   logic [4:0]      r_rd;
   logic            r_gpr_we;
   logic [XLEN-1:0] r_gpr_wdata;
   logic            r_csr_we;
   logic [11:0]     r_csr_addr;
   logic [XLEN-1:0] r_csr_wdata;
   logic [XLEN-1:0] r_next_pc;
   logic [XLEN-1:0] r_commit_pc;

   logic [XLEN-1:0] r_gpr [NR_REG];
   logic [XLEN-1:0] r_mstatus, r_mtvec, r_mepc, r_mcause;

   logic w_accept;
   logic w_write;
   logic w_gpr_wen;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default first so no path leaves w_state_nxt unassigned (no inferred latch).
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (wb_valid) w_state_nxt = S_WRITE;
         S_WRITE: w_state_nxt = S_DONE;
         S_DONE:  if (ifu_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign gpr_ready    = (r_state == S_IDLE);
   assign commit_valid = (r_state == S_DONE);
   assign commit_pc    = r_commit_pc;

   assign w_accept  = wb_valid && gpr_ready;
   assign w_write   = (r_state == S_WRITE);
   assign w_gpr_wen = r_gpr_we && (r_rd != 5'd0) && (32'(r_rd) < NR_REG_U);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd        <= '0;
         r_gpr_we    <= 1'b0;
         r_gpr_wdata <= '0;
         r_csr_we    <= 1'b0;
         r_csr_addr  <= '0;
         r_csr_wdata <= '0;
         r_next_pc   <= '0;
      end else if (w_accept) begin
         r_rd        <= wb_rd;
         r_gpr_we    <= wb_gpr_we;
         r_gpr_wdata <= wb_gpr_wdata;
         r_csr_we    <= wb_csr_we;
         r_csr_addr  <= wb_csr_addr;
         r_csr_wdata <= wb_csr_wdata;
         r_next_pc   <= wb_next_pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         r_commit_pc <= RST_PC;
      else if (w_write) r_commit_pc <= r_next_pc;
   end

   // NOTE: the register file is architecturally reset to zero, so the array sits in the reset branch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NR_REG; i++) r_gpr[i] <= '0;
      end else if (w_write && w_gpr_wen) begin
         r_gpr[r_rd[AW-1:0]] <= r_gpr_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mstatus <= MSTATUS_RST;
         r_mtvec   <= '0;
         r_mepc    <= '0;
         r_mcause  <= '0;
      end else if (w_write && r_csr_we) begin
         case (r_csr_addr)
            CSR_MSTATUS: r_mstatus <= r_csr_wdata;
            CSR_MTVEC:   r_mtvec   <= r_csr_wdata;
            CSR_MEPC:    r_mepc    <= r_csr_wdata;
            CSR_MCAUSE:  r_mcause  <= r_csr_wdata;
            default:     ;
         endcase
      end
   end

   // x0 and indices beyond the implemented file read as zero.
   assign rs1_data = ((rs1_addr != 5'd0) && (32'(rs1_addr) < NR_REG_U)) ? r_gpr[rs1_addr[AW-1:0]] : '0;
   assign rs2_data = ((rs2_addr != 5'd0) && (32'(rs2_addr) < NR_REG_U)) ? r_gpr[rs2_addr[AW-1:0]] : '0;

   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         CSR_MSTATUS: csr_rdata = r_mstatus;
         CSR_MTVEC:   csr_rdata = r_mtvec;
         CSR_MEPC:    csr_rdata = r_mepc;
         CSR_MCAUSE:  csr_rdata = r_mcause;
         default:     csr_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25020037_gpr_commit.sv
// Self-checking bench for the commit stage: vector table of retired packets,
// commit-PC scoreboard, plus backpressure and mid-write reset sequences.
module tb_ysyx_25020037_gpr_commit;

   localparam logic [31:0] RST_PC = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_gpr_we;
   logic [31:0] wb_gpr_wdata;
   logic        wb_csr_we;
   logic [11:0] wb_csr_addr;
   logic [31:0] wb_csr_wdata;
   logic [31:0] wb_next_pc;
   logic        ifu_ready;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [11:0] csr_raddr;

   logic        gpr_ready, commit_valid;
   logic [31:0] commit_pc, rs1_data, rs2_data, csr_rdata;
   logic        e_gpr_ready, e_commit_valid;
   logic [31:0] e_commit_pc, e_rs1_data, e_rs2_data, e_csr_rdata;

   always #5 clk = ~clk;

   ysyx_25020037_gpr_commit #(.NR_REG(32), .XLEN(32), .RST_PC(RST_PC)) u_dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .gpr_ready(gpr_ready),
      .wb_rd(wb_rd), .wb_gpr_we(wb_gpr_we), .wb_gpr_wdata(wb_gpr_wdata),
      .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata),
      .wb_next_pc(wb_next_pc), .commit_valid(commit_valid), .ifu_ready(ifu_ready),
      .commit_pc(commit_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata)
   );

   // RV32E build fed the same packets; registers 16..31 must not exist there.
   ysyx_25020037_gpr_commit #(.NR_REG(16), .XLEN(32), .RST_PC(RST_PC)) u_dut_e (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .gpr_ready(e_gpr_ready),
      .wb_rd(wb_rd), .wb_gpr_we(wb_gpr_we), .wb_gpr_wdata(wb_gpr_wdata),
      .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata),
      .wb_next_pc(wb_next_pc), .commit_valid(e_commit_valid), .ifu_ready(ifu_ready),
      .commit_pc(e_commit_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(e_rs1_data), .rs2_data(e_rs2_data), .csr_raddr(csr_raddr), .csr_rdata(e_csr_rdata)
   );

   typedef struct packed {
      logic [4:0]  rd;
      logic        gpr_we;
      logic [31:0] gpr_wdata;
      logic        csr_we;
      logic [11:0] csr_addr;
      logic [31:0] csr_wdata;
      logic [31:0] next_pc;
      logic [31:0] exp_gpr;
      logic [31:0] exp_csr;
   } vec_t;

   vec_t        vecs [7];
   logic [31:0] sb_q [$];
   logic [31:0] m_gpr [32];
   int          n_vec  = 0;
   int          n_miss = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_pkt(input vec_t v);
      wb_rd        = v.rd;
      wb_gpr_we    = v.gpr_we;
      wb_gpr_wdata = v.gpr_wdata;
      wb_csr_we    = v.csr_we;
      wb_csr_addr  = v.csr_addr;
      wb_csr_wdata = v.csr_wdata;
      wb_next_pc   = v.next_pc;
      wb_valid     = 1'b1;
   endtask

   // One packet with ifu_ready held high: commit expected at N+2, ready at N+3.
   task automatic send(input vec_t v);
      int          lat;
      logic [31:0] exp_pc;
      lat = 0;
      while (!gpr_ready && lat < 8) begin
         tick();
         lat++;
      end
      check("ready_before_send", 32'(gpr_ready), 32'd1);
      ifu_ready = 1'b1;
      drive_pkt(v);
      sb_q.push_back(v.next_pc);
      if (v.gpr_we && v.rd != 5'd0) m_gpr[v.rd] = v.gpr_wdata;
      tick();
      wb_valid = 1'b0;
      check("ready_low_in_write", 32'(gpr_ready), 32'd0);
      lat = 1;
      while (!commit_valid && lat < 8) begin
         tick();
         lat++;
      end
      check("commit_latency", 32'(lat), 32'd2);
      if (commit_valid && sb_q.size() > 0) begin
         exp_pc = sb_q.pop_front();
         check("commit_pc", commit_pc, exp_pc);
      end
      rs1_addr  = v.rd;
      rs2_addr  = v.rd;
      csr_raddr = v.csr_addr;
      #1;
      check("gpr_rs1", rs1_data, v.exp_gpr);
      check("gpr_rs2", rs2_data, v.exp_gpr);
      check("csr_read", csr_rdata, v.exp_csr);
      tick();
      check("commit_one_cycle", 32'(commit_valid), 32'd0);
      check("ready_at_n3", 32'(gpr_ready), 32'd1);
   endtask

   initial begin
      vec_t        bp, junk, abort_v, rec;
      logic [31:0] held_pc;

      vecs[0] = '{5'd5,  1'b1, 32'hDEAD_BEEF, 1'b0, 12'h300, 32'h0,         32'h3000_0004, 32'hDEAD_BEEF, 32'h0000_1800};
      vecs[1] = '{5'd0,  1'b1, 32'h0000_1234, 1'b0, 12'h300, 32'h0,         32'h3000_0008, 32'h0,         32'h0000_1800};
      vecs[2] = '{5'd10, 1'b1, 32'h0,         1'b1, 12'h305, 32'h8000_0100, 32'h3000_000C, 32'h0,         32'h8000_0100};
      vecs[3] = '{5'd31, 1'b1, 32'hA5A5_5A5A, 1'b1, 12'h341, 32'h3000_0010, 32'h3000_0010, 32'hA5A5_5A5A, 32'h3000_0010};
      vecs[4] = '{5'd6,  1'b0, 32'hFFFF_FFFF, 1'b1, 12'h7C0, 32'h0000_0001, 32'h3000_0014, 32'h0,         32'h0};
      vecs[5] = '{5'd1,  1'b1, 32'h0000_0001, 1'b1, 12'h342, 32'h8000_000B, 32'h3000_0018, 32'h0000_0001, 32'h8000_000B};
      vecs[6] = '{5'd5,  1'b1, 32'h1111_2222, 1'b1, 12'h300, 32'h0000_0088, 32'h8000_0000, 32'h1111_2222, 32'h0000_0088};
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;

      rst = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_gpr_we = 1'b0; wb_gpr_wdata = '0;
      wb_csr_we = 1'b0; wb_csr_addr = '0; wb_csr_wdata = '0; wb_next_pc = '0;
      ifu_ready = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0; csr_raddr = 12'h300;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("rst_gpr_ready", 32'(gpr_ready), 32'd1);
      check("rst_commit_valid", 32'(commit_valid), 32'd0);
      check("rst_commit_pc", commit_pc, RST_PC);
      check("rst_x5", rs1_data, 32'h0);
      check("rst_mstatus", csr_rdata, 32'h0000_1800);

      for (int i = 0; i < 7; i++) send(vecs[i]);

      // Unchanged CSRs after the table, and the RV32E instance view.
      csr_raddr = 12'h305; #1;
      check("mtvec_kept", csr_rdata, 32'h8000_0100);
      rs1_addr = 5'd31; rs2_addr = 5'd5; #1;
      check("rv32e_x31_zero", e_rs1_data, 32'h0);
      check("rv32e_x5", e_rs2_data, 32'h1111_2222);

      // Backpressure: IFU stalls four cycles; a second packet must be ignored.
      bp   = '{5'd20, 1'b1, 32'h2020_2020, 1'b0, 12'h0, 32'h0, 32'h3000_0100, 32'h0, 32'h0};
      junk = '{5'd7,  1'b1, 32'hBAD0_BAD0, 1'b1, 12'h305, 32'h0, 32'h0000_DEAD, 32'h0, 32'h0};
      ifu_ready = 1'b0;
      drive_pkt(bp);
      sb_q.push_back(bp.next_pc);
      m_gpr[20] = bp.gpr_wdata;
      tick();
      wb_valid = 1'b0;
      tick();
      check("bp_commit_valid", 32'(commit_valid), 32'd1);
      held_pc = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         check("bp_hold_valid", 32'(commit_valid), 32'd1);
         check("bp_hold_pc", commit_pc, held_pc);
         check("bp_ready_low", 32'(gpr_ready), 32'd0);
         if (i == 1) drive_pkt(junk);
         tick();
      end
      wb_valid = 1'b0;
      check("bp_still_valid", 32'(commit_valid), 32'd1);
      ifu_ready = 1'b1;
      tick();
      check("bp_release_valid", 32'(commit_valid), 32'd0);
      check("bp_release_ready", 32'(gpr_ready), 32'd1);
      check("bp_pc_after", commit_pc, held_pc);
      rs1_addr = 5'd7; rs2_addr = 5'd20; csr_raddr = 12'h305; #1;
      check("bp_junk_gpr", rs1_data, 32'h0);
      check("bp_junk_csr", csr_rdata, 32'h8000_0100);
      check("bp_written", rs2_data, 32'h2020_2020);
      tick();
      check("bp_no_extra_commit", 32'(commit_valid), 32'd0);

      // Reset asserted while the packet sits in WRITE: nothing is retained.
      abort_v = '{5'd12, 1'b1, 32'hCAFE_F00D, 1'b1, 12'h342, 32'h0000_5555, 32'h3000_0300, 32'h0, 32'h0};
      drive_pkt(abort_v);
      tick();
      wb_valid = 1'b0;
      check("abort_in_write", 32'(gpr_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("abort_commit_valid", 32'(commit_valid), 32'd0);
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      rs1_addr = 5'd12; rs2_addr = 5'd5; csr_raddr = 12'h342; #1;
      check("abort_x12", rs1_data, 32'h0);
      check("abort_x5", rs2_data, 32'h0);
      check("abort_mcause", csr_rdata, 32'h0);
      check("abort_idle", 32'(gpr_ready), 32'd1);
      check("abort_commit_pc", commit_pc, RST_PC);
      tick();
      check("abort_no_commit", 32'(commit_valid), 32'd0);

      rec = '{5'd12, 1'b1, 32'h1357_9BDF, 1'b1, 12'h300, 32'h0000_1888, 32'h3000_0200, 32'h1357_9BDF, 32'h0000_1888};
      send(rec);

      for (int i = 0; i < 32; i++) begin
         rs2_addr = 5'(i);
         #1;
         check("final_sweep", rs2_data, m_gpr[i]);
      end
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ysyx_25020037_gpr_commit.md
Name: ysyx_25020037_gpr_commit

Overview:
- Receiver and commit stage for the write-back handshake in the multi-cycle core.
- Accepts one retired-instruction packet per handshake: GPR write, CSR write, next PC.
- Updates the architectural register file (x0 hardwired to zero) and a four-entry machine CSR file.
- Raises commit_valid toward the IFU, which starts the next fetch.
- Also exposes two combinational GPR read ports and one CSR read port for the IDU.

Parameters:
- NR_REG, 32, number of GPRs (16 for RV32E builds); index width is log2(NR_REG).
- XLEN, 32, datapath width.
- RST_PC, 32'h3000_0000, PC driven on commit_pc after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- wb_valid  in  1  write-back packet valid
- gpr_ready  out  1  commit stage can accept a packet
- wb_rd  in  5  destination register index
- wb_gpr_we  in  1  GPR write enable
- wb_gpr_wdata  in  XLEN  GPR write data
- wb_csr_we  in  1  CSR write enable
- wb_csr_addr  in  12  CSR address
- wb_csr_wdata  in  XLEN  CSR write data
- wb_next_pc  in  XLEN  PC of next instruction
- commit_valid  out  1  retirement done, next PC valid
- ifu_ready  in  1  IFU accepts commit
- commit_pc  out  XLEN  next fetch PC
- rs1_addr, rs2_addr  in  5  read indices
- rs1_data, rs2_data  out  XLEN  combinational read data
- csr_raddr  in  12  CSR read address
- csr_rdata  out  XLEN  combinational CSR read data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gpr_ready=1, commit_valid=0, commit_pc=RST_PC.
  - All GPRs=0; mstatus=32'h1800, mtvec=0, mepc=0, mcause=0.
  - Reset asserted mid-operation aborts any pending write; nothing partial is retained.
- State IDLE:
  - gpr_ready=1.
  - On wb_valid&gpr_ready: latch all wb_* fields, gpr_ready<=0, go to WRITE.
- State WRITE (exactly 1 cycle):
  - If latched gpr_we && rd!=0 && rd<NR_REG: write GPR.
  - If latched csr_we: write the addressed CSR. Implemented addresses: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause. Any other address is ignored.
  - commit_pc<=latched next_pc, commit_valid<=1, go to DONE.
- State DONE:
  - Hold commit_valid=1 and commit_pc stable until ifu_ready=1.
  - On that cycle: commit_valid<=0, gpr_ready<=1, go to IDLE.
  - If ifu_ready is already 1 on entry, DONE lasts exactly 1 cycle.
- Latency: handshake cycle N -> register file updated at edge N+1 -> commit_valid high during N+2 -> earliest next accept at N+3.
- wb_valid while gpr_ready=0 is ignored; the upstream holds it.
- Read ports:
  - Purely combinational from the array.
  - Index 0 always returns 0. Index >= NR_REG returns 0.
  - No write-to-read bypass; the next instruction is only fetched after commit.
- Simultaneous GPR and CSR write in one packet (csrrw): both are performed in the same WRITE cycle.
- GPR write to x0: ignored. CSR write to an unimplemented address: ignored. Neither suppresses the commit.
- No other state exists. Any illegal state encoding returns to IDLE on the next clock.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> gpr_ready=1, commit_valid=0, commit_pc=32'h3000_0000, rs1_data for x5 = 0, csr_rdata(0x300)=32'h1800.
- Basic write: wb_rd=5, gpr_we=1, wdata=32'hDEAD_BEEF, next_pc=32'h3000_0004, ifu_ready=1.
  - Expect: rs1(5)=DEADBEEF at N+2; commit_valid for exactly 1 cycle with commit_pc=3000_0004; gpr_ready back at N+3.
- x0 protection: wb_rd=0, gpr_we=1, wdata=32'h1234 -> rs2(0)=0; commit still occurs.
- csrrw: rd=10, gpr_wdata=old mtvec (0), csr_we=1, addr=0x305, csr_wdata=32'h8000_0100.
  - Expect: x10=0 and csr_rdata(0x305)=8000_0100 after the same WRITE cycle.
- Backpressure: ifu_ready=0 for 4 cycles after commit.
  - Expect: commit_valid and commit_pc held stable, gpr_ready=0; a new wb_valid packet is ignored until ifu_ready=1.
- Mid-operation reset: assert rst=0 during WRITE.
  - Expect: the target register reads 0, commit_valid=0, state IDLE after release.
